// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares BRAM port B between the core load/store path (M0)
// and an auxiliary master (M1). It grants one access per cycle, routes the
// winner's address, data and byte enables to the memory, and returns read
// data or range errors to the right master after the fixed BRAM latency.
module mem_port_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0,
  parameter int STARVE_MAX   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic [3:0]        m0_we_i,
  input  logic [31:0]       m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic [3:0]        m1_we_i,
  input  logic [31:0]       m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_we_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } resp_t;

  owner_e           last_grant;
  logic [CNT_W-1:0] starve_cnt;
  resp_t            pipe [READ_LATENCY];

  logic        m1_wins;
  logic        gnt0;
  logic        gnt1;
  logic        gnt_any;
  logic [3:0]  sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_oor;
  resp_t       new_resp;
  resp_t       head;

  // Byte-lane offset bits never reach the word-addressed port.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  // Grant decision: single requester wins outright; contention is settled by
  // round-robin or by M0 priority with the M1 starvation guard.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    m1_wins = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (m0_req_i && m1_req_i) begin
      if (FIXED_PRIO != 0) begin
        m1_wins = (starve_cnt == CNT_W'(STARVE_MAX - 1));
      end else begin
        m1_wins = (last_grant == OWNER_M0);
      end
      gnt0 = !m1_wins;
      gnt1 = m1_wins;
    end else begin
      gnt0 = m0_req_i;
      gnt1 = m1_req_i;
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Route the winner to the memory; with no grant the M0 payload is shown
  // but writes are disabled.
  always_comb begin
    sel_we    = m0_we_i;
    sel_addr  = m0_addr_i;
    sel_wdata = m0_wdata_i;
    if (gnt1) begin
      sel_we    = m1_we_i;
      sel_addr  = m1_addr_i;
      sel_wdata = m1_wdata_i;
    end
    sel_oor    = |sel_addr[31:ADDR_W+2];
    mem_addr_o = sel_addr[ADDR_W+1:2];
    mem_din_o  = sel_wdata;
    mem_we_o   = (gnt_any && !sel_oor) ? sel_we : 4'b0000;
  end

  // Reads and every out-of-range access produce a response; in-range writes
  // complete silently.
  always_comb begin
    new_resp.valid = gnt_any && ((sel_we == 4'b0000) || sel_oor);
    new_resp.owner = gnt1 ? OWNER_M1 : OWNER_M0;
    new_resp.err   = sel_oor;
  end

  // Arbitration history: last winner for round-robin, denied-cycle count
  // for the starvation guard.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant <= OWNER_M1;
      starve_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (gnt_any) begin
        last_grant <= gnt1 ? OWNER_M1 : OWNER_M0;
      end
      if ((FIXED_PRIO != 0) && m1_req_i && !gnt1) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Response tags travel alongside the BRAM read so they line up with
  // mem_dout_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the tag pipeline is cleared entry by entry; a stale valid bit
      // surviving reset would fire a spurious rvalid after release.
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= new_resp;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign head = pipe[READ_LATENCY-1];

  // Steer the returning response to its owner; data is zero unless a
  // clean read is being returned.
  always_comb begin
    m0_rvalid_o = head.valid && (head.owner == OWNER_M0);
    m1_rvalid_o = head.valid && (head.owner == OWNER_M1);
    m0_err_o    = m0_rvalid_o && head.err;
    m1_err_o    = m1_rvalid_o && head.err;
    m0_rdata_o  = (m0_rvalid_o && !head.err) ? mem_dout_i : 32'h0;
    m1_rdata_o  = (m1_rvalid_o && !head.err) ? mem_dout_i : 32'h0;
  end

endmodule
